// File: rtl/gsu_pkg.sv
// rtl/gsu_pkg.sv - shared types and constants for the GSU fetch stage
package gsu_pkg;

  localparam int LINE_BYTES  = 16;
  localparam int LINES       = 32;
  localparam int CACHE_BYTES = LINE_BYTES * LINES;

  // SNES-side MMIO address of cache byte 0; snes_addr arrives already rebased to it
  localparam logic [15:0] MMIO_CACHE_BASE = 16'h3100;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_LOOKUP,
    ST_READ,
    ST_FILL,
    ST_DIRECT
  } fetch_state_t;

  // Cache offset of a program address relative to CBR, wrapping modulo 2^16
  function automatic logic [15:0] cache_offset(input logic [15:0] pc, input logic [15:0] base);
    return pc - base;
  endfunction

endpackage

// File: rtl/gsu_cache_ram.sv
// rtl/gsu_cache_ram.sv - byte-wide simple dual-port cache RAM with registered read
module gsu_cache_ram #(
  parameter int DEPTH = 512,
  parameter int AW    = 9
) (
  input  logic          clkin,
  input  logic          we,
  input  logic [AW-1:0] waddr,
  input  logic [7:0]    wdata,
  input  logic          re,
  input  logic [AW-1:0] raddr,
  output logic [7:0]    rdata
);

  logic [7:0] mem [DEPTH];

  // Write port and registered read port; contents are never cleared
  always_ff @(posedge clkin) begin
    if (we) begin
      mem[waddr] <= wdata;
    end
    if (re) begin
      rdata <= mem[raddr];
    end
  end

endmodule

// File: rtl/gsu_fetch.sv
// rtl/gsu_fetch.sv - GSU opcode fetch stage with CBR-relative instruction cache
module gsu_fetch #(
  parameter int LINE_BYTES = gsu_pkg::LINE_BYTES,
  parameter int LINES      = gsu_pkg::LINES
) (
  input  logic        clkin,
  input  logic        reset,
  input  logic        fetch_req,
  input  logic [23:0] fetch_addr,
  input  logic [15:0] cbr,
  output logic        fetch_ack,
  output logic [7:0]  fetch_data,
  input  logic        flush,
  input  logic        go,
  input  logic        snes_wr,
  input  logic [8:0]  snes_addr,
  input  logic [7:0]  snes_di,
  output logic        rom_req,
  output logic [23:0] rom_addr,
  input  logic        rom_ack,
  input  logic [7:0]  rom_data,
  output logic        busy
);

  import gsu_pkg::*;

  localparam int CACHE_SIZE = LINE_BYTES * LINES;
  localparam int OFF_W      = $clog2(CACHE_SIZE);
  localparam int BYTE_W     = $clog2(LINE_BYTES);
  localparam int LINE_W     = OFF_W - BYTE_W;

  fetch_state_t      state;
  logic [23:0]       addr_q;
  logic [15:0]       cbr_q;
  logic [15:0]       off_q;
  logic [BYTE_W-1:0] k_q;
  logic              flush_seen_q;
  logic              from_fill_q;
  logic [7:0]        fill_byte_q;
  logic [LINES-1:0]  valid;

  logic              in_window;
  logic [LINE_W-1:0] line_w;
  logic [BYTE_W-1:0] byte_w;
  logic              fill_hit;
  logic              fill_last;
  logic              snes_ok;
  logic [OFF_W-1:0]  snes_off;

  logic              ram_we;
  logic [OFF_W-1:0]  ram_waddr;
  logic [7:0]        ram_wdata;
  logic              ram_re;
  logic [7:0]        ram_rdata;

  assign in_window = off_q < 16'(CACHE_SIZE);
  assign line_w    = off_q[OFF_W-1:BYTE_W];
  assign byte_w    = off_q[BYTE_W-1:0];
  assign fill_hit  = (state == ST_FILL) && rom_req && rom_ack;
  assign fill_last = fill_hit && (k_q == '1);
  assign snes_ok   = snes_wr && !go;
  assign snes_off  = OFF_W'(snes_addr);
  assign busy      = (state != ST_IDLE);

  // Single write port shared by line fills and SNES writes; go keeps them apart,
  // the fill still takes priority so a stray SNES strobe cannot corrupt a line
  always_comb begin
    ram_we    = fill_hit || snes_ok;
    ram_waddr = snes_off;
    ram_wdata = snes_di;
    if (fill_hit) begin
      ram_waddr = {line_w, k_q};
      ram_wdata = rom_data;
    end
  end

  assign ram_re = (state == ST_LOOKUP);

  gsu_cache_ram #(
    .DEPTH (CACHE_SIZE),
    .AW    (OFF_W)
  ) u_ram (
    .clkin (clkin),
    .we    (ram_we),
    .waddr (ram_waddr),
    .wdata (ram_wdata),
    .re    (ram_re),
    .raddr (off_q[OFF_W-1:0]),
    .rdata (ram_rdata)
  );

  // Line-valid bits: flush clears everything and beats any set in the same cycle
  always_ff @(posedge clkin) begin
    if (reset) begin
      valid <= '0;
    end else if (flush) begin
      valid <= '0;
    end else begin
      if (fill_last && !flush_seen_q) begin
        valid[line_w] <= 1'b1;
      end
      if (snes_ok && (snes_off[BYTE_W-1:0] == '1)) begin
        valid[snes_off[OFF_W-1:BYTE_W]] <= 1'b1;
      end
    end
  end

  // Fetch FSM: request capture, lookup, line fill, uncached read and response
  always_ff @(posedge clkin) begin
    if (reset) begin
      state        <= ST_IDLE;
      fetch_ack    <= 1'b0;
      fetch_data   <= 8'h00;
      rom_req      <= 1'b0;
      rom_addr     <= 24'h0;
      addr_q       <= 24'h0;
      cbr_q        <= 16'h0;
      off_q        <= 16'h0;
      k_q          <= '0;
      flush_seen_q <= 1'b0;
      from_fill_q  <= 1'b0;
      fill_byte_q  <= 8'h00;
    end else begin
      fetch_ack <= 1'b0;
      case (state)
        ST_IDLE: begin
          if (fetch_req) begin
            addr_q <= fetch_addr;
            cbr_q  <= cbr;
            off_q  <= cache_offset(fetch_addr[15:0], cbr);
            state  <= ST_LOOKUP;
          end
        end
        ST_LOOKUP: begin
          if (!in_window) begin
            rom_req  <= 1'b1;
            rom_addr <= addr_q;
            state    <= ST_DIRECT;
          end else if (valid[line_w] && !flush) begin
            from_fill_q <= 1'b0;
            state       <= ST_READ;
          end else begin
            k_q          <= '0;
            flush_seen_q <= 1'b0;
            rom_req      <= 1'b1;
            rom_addr     <= {addr_q[23:16], cbr_q + 16'({line_w, {BYTE_W{1'b0}}})};
            state        <= ST_FILL;
          end
        end
        ST_READ: begin
          fetch_data <= from_fill_q ? fill_byte_q : ram_rdata;
          fetch_ack  <= 1'b1;
          state      <= ST_IDLE;
        end
        ST_FILL: begin
          if (flush) begin
            flush_seen_q <= 1'b1;
          end
          if (rom_req && rom_ack) begin
            rom_req <= 1'b0;
            // Keep the requested byte aside so READ does not race the RAM write
            if (k_q == byte_w) begin
              fill_byte_q <= rom_data;
            end
            if (k_q == '1) begin
              from_fill_q <= 1'b1;
              state       <= ST_READ;
            end else begin
              k_q <= k_q + 1'b1;
            end
          end else if (!rom_req) begin
            rom_req  <= 1'b1;
            rom_addr <= {addr_q[23:16], cbr_q + 16'({line_w, k_q})};
          end
        end
        ST_DIRECT: begin
          if (rom_req && rom_ack) begin
            rom_req    <= 1'b0;
            fetch_data <= rom_data;
            fetch_ack  <= 1'b1;
            state      <= ST_IDLE;
          end
        end
        default: begin
          rom_req <= 1'b0;
          state   <= ST_IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_gsu_fetch.sv
// tb/tb_gsu_fetch.sv - directed self-checking bench for gsu_fetch
module tb_gsu_fetch;

  logic        clkin;
  logic        reset;
  logic        fetch_req;
  logic [23:0] fetch_addr;
  logic [15:0] cbr;
  logic        fetch_ack;
  logic [7:0]  fetch_data;
  logic        flush;
  logic        go;
  logic        snes_wr;
  logic [8:0]  snes_addr;
  logic [7:0]  snes_di;
  logic        rom_req;
  logic [23:0] rom_addr;
  logic        rom_ack;
  logic [7:0]  rom_data;
  logic        busy;

  int          n_checks;
  int          n_pass;
  logic [23:0] addr_log [32];
  logic [7:0]  d;
  int          lat;
  int          nr;
  bit          ok;

  gsu_fetch dut (
    .clkin      (clkin),
    .reset      (reset),
    .fetch_req  (fetch_req),
    .fetch_addr (fetch_addr),
    .cbr        (cbr),
    .fetch_ack  (fetch_ack),
    .fetch_data (fetch_data),
    .flush      (flush),
    .go         (go),
    .snes_wr    (snes_wr),
    .snes_addr  (snes_addr),
    .snes_di    (snes_di),
    .rom_req    (rom_req),
    .rom_addr   (rom_addr),
    .rom_ack    (rom_ack),
    .rom_data   (rom_data),
    .busy       (busy)
  );

  initial clkin = 1'b0;
  always #5 clkin = ~clkin;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks = n_checks + 1;
    assert (obs === exp) begin
      n_pass = n_pass + 1;
    end else begin
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  // Issue one fetch and act as the ROM (data = addr[7:0]^A5, ack one cycle after req seen).
  // flush_at pulses flush alongside that numbered ack; abort_at returns once that many
  // reads were served and the next request is up, without answering it.
  task automatic do_fetch(input logic [23:0] a, input int flush_at, input int abort_at,
                          output logic [7:0] data, output int latency, output int nreads,
                          output bit got_ack);
    fetch_addr = a;
    fetch_req  = 1'b1;
    nreads     = 0;
    latency    = 0;
    got_ack    = 1'b0;
    data       = 8'h00;
    for (int c = 0; c < 400; c++) begin
      @(negedge clkin);
      rom_ack = 1'b0;
      flush   = 1'b0;
      latency = latency + 1;
      if (fetch_ack) begin
        data    = fetch_data;
        got_ack = 1'b1;
        break;
      end
      if (abort_at != 0 && nreads == abort_at && rom_req) begin
        break;
      end
      if (rom_req) begin
        if (nreads < 32) begin
          addr_log[nreads] = rom_addr;
        end
        rom_data = rom_addr[7:0] ^ 8'hA5;
        rom_ack  = 1'b1;
        nreads   = nreads + 1;
        if (nreads == flush_at) begin
          flush = 1'b1;
        end
      end
    end
    fetch_req = 1'b0;
  endtask

  task automatic snes_write(input logic [8:0] a, input logic [7:0] v);
    snes_addr = a;
    snes_di   = v;
    snes_wr   = 1'b1;
    @(negedge clkin);
    snes_wr   = 1'b0;
  endtask

  initial begin
    n_checks   = 0;
    n_pass     = 0;
    reset      = 1'b1;
    fetch_req  = 1'b0;
    fetch_addr = 24'h0;
    cbr        = 16'h0000;
    flush      = 1'b0;
    go         = 1'b1;
    snes_wr    = 1'b0;
    snes_addr  = 9'h0;
    snes_di    = 8'h0;
    rom_ack    = 1'b0;
    rom_data   = 8'h0;
    repeat (3) @(negedge clkin);
    chk("rst_fetch_ack", 32'(fetch_ack), 32'h0);
    chk("rst_fetch_data", 32'(fetch_data), 32'h0);
    chk("rst_rom_req", 32'(rom_req), 32'h0);
    chk("rst_rom_addr", 32'(rom_addr), 32'h0);
    chk("rst_busy", 32'(busy), 32'h0);
    chk("rst_valid", dut.valid, 32'h0);
    reset = 1'b0;
    @(negedge clkin);

    // Cold miss on line 0
    do_fetch(24'h010005, 0, 0, d, lat, nr, ok);
    chk("fill0_ack", 32'(ok), 32'h1);
    chk("fill0_reads", 32'(nr), 32'd16);
    for (int i = 0; i < 16; i++) begin
      chk($sformatf("fill0_addr%0d", i), 32'(addr_log[i]), 32'h010000 + 32'(i));
    end
    chk("fill0_data", 32'(d), 32'hA0);
    chk("fill0_valid", dut.valid, 32'h1);

    // Hit on the freshly filled line
    do_fetch(24'h01000A, 0, 0, d, lat, nr, ok);
    chk("hit_ack", 32'(ok), 32'h1);
    chk("hit_reads", 32'(nr), 32'd0);
    chk("hit_latency", 32'(lat), 32'd3);
    chk("hit_data", 32'(d), 32'hAF);

    // Address below CBR wraps to a huge offset and goes uncached
    cbr = 16'h8000;
    do_fetch(24'h017FFF, 0, 0, d, lat, nr, ok);
    chk("direct_ack", 32'(ok), 32'h1);
    chk("direct_reads", 32'(nr), 32'd1);
    chk("direct_addr", 32'(addr_log[0]), 32'h017FFF);
    chk("direct_data", 32'(d), 32'h5A);
    chk("direct_valid", dut.valid, 32'h1);

    // Flush on the 5th ack of a line-2 fill
    do_fetch(24'h028025, 5, 0, d, lat, nr, ok);
    chk("flfill_ack", 32'(ok), 32'h1);
    chk("flfill_reads", 32'(nr), 32'd16);
    chk("flfill_addr4", 32'(addr_log[4]), 32'h028024);
    chk("flfill_addr15", 32'(addr_log[15]), 32'h02802F);
    chk("flfill_data", 32'(d), 32'h80);
    chk("flfill_valid", dut.valid, 32'h0);
    do_fetch(24'h028021, 0, 0, d, lat, nr, ok);
    chk("refill_reads", 32'(nr), 32'd16);
    chk("refill_data", 32'(d), 32'h84);
    chk("refill_valid", dut.valid, 32'h4);

    // SNES preload of line 1 while stopped
    go = 1'b0;
    for (int i = 0; i < 16; i++) begin
      snes_write(9'h010 + 9'(i), 8'h3C);
    end
    chk("snes_valid", dut.valid, 32'h6);
    go = 1'b1;
    do_fetch(24'h008014, 0, 0, d, lat, nr, ok);
    chk("snes_hit_reads", 32'(nr), 32'd0);
    chk("snes_hit_data", 32'(d), 32'h3C);
    snes_write(9'h014, 8'h77);
    snes_write(9'h03F, 8'h11);
    chk("snes_go_valid", dut.valid, 32'h6);
    do_fetch(24'h008014, 0, 0, d, lat, nr, ok);
    chk("snes_go_reads", 32'(nr), 32'd0);
    chk("snes_go_data", 32'(d), 32'h3C);

    // Window edges: offset 511 is cached, offset 512 is not
    do_fetch(24'h0081FF, 0, 0, d, lat, nr, ok);
    chk("edge511_reads", 32'(nr), 32'd16);
    chk("edge511_addr0", 32'(addr_log[0]), 32'h0081F0);
    chk("edge511_data", 32'(d), 32'h5A);
    chk("edge511_valid", dut.valid, 32'h8000_0006);
    do_fetch(24'h008200, 0, 0, d, lat, nr, ok);
    chk("edge512_reads", 32'(nr), 32'd1);
    chk("edge512_addr", 32'(addr_log[0]), 32'h008200);
    chk("edge512_data", 32'(d), 32'hA5);

    // Reset in the middle of a fill, then a stray ack
    do_fetch(24'h008065, 0, 3, d, lat, nr, ok);
    chk("abort_noack", 32'(ok), 32'h0);
    chk("abort_reads", 32'(nr), 32'd3);
    chk("abort_req_up", 32'(rom_req), 32'h1);
    chk("abort_busy", 32'(busy), 32'h1);
    reset = 1'b1;
    @(negedge clkin);
    chk("midrst_rom_req", 32'(rom_req), 32'h0);
    chk("midrst_valid", dut.valid, 32'h0);
    chk("midrst_busy", 32'(busy), 32'h0);
    reset = 1'b0;
    @(negedge clkin);
    rom_data = 8'h55;
    rom_ack  = 1'b1;
    @(negedge clkin);
    rom_ack  = 1'b0;
    chk("stray_busy", 32'(busy), 32'h0);
    chk("stray_rom_req", 32'(rom_req), 32'h0);
    chk("stray_fetch_ack", 32'(fetch_ack), 32'h0);
    @(negedge clkin);
    chk("stray_busy2", 32'(busy), 32'h0);
    chk("stray_valid", dut.valid, 32'h0);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
